// File: rtl/avmm_gpio_pkg.sv
// Shared constants and types for the Avalon-MM GPIO agent.
// Optional heartbeat LED mode is enabled by defining AVMM_GPIO_HEARTBEAT_EN.
package avmm_gpio_pkg;

    localparam int LED_W = 8;
    localparam int KEY_W = 2;
    localparam int SW_W  = 4;
    localparam int IN_W  = KEY_W + SW_W;

    localparam logic [2:0] ADDR_LED_OUT  = 3'd0;
    localparam logic [2:0] ADDR_LED_MODE = 3'd1;
    localparam logic [2:0] ADDR_INPUTS   = 3'd2;
    localparam logic [2:0] ADDR_EDGE     = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_ID       = 3'd5;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h4445_3130;

    // Debounced inputs as they leave the debouncer: SW in the high bits, KEY (active-high) low.
    typedef struct packed {
        logic [SW_W-1:0]  sw;
        logic [KEY_W-1:0] key;
    } gpio_in_t;

endpackage

// File: rtl/avmm_gpio_agent_debounce.sv
// gpio_debounce: 2-FF synchroniser plus a per-bit stability counter.
// The debounced bit follows the synchronised bit once it has differed for DEBOUNCE_CYCLES cycles.
module gpio_debounce #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] deb
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [CNT_W-1:0] cnt [WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            sync <= '0;
            deb  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            meta <= raw;
            sync <= meta;
            for (int i = 0; i < WIDTH; i++) begin
                // Agreement holds the counter at zero, so any bounce restarts the window.
                if (sync[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/avmm_gpio_agent.sv
// Avalon-MM GPIO responder: LED drive, debounced KEY/SW readback, KEY edge capture and IRQ.
// Define AVMM_GPIO_HEARTBEAT_EN to build the heartbeat counter behind LED_MODE.
module avmm_gpio_agent
    import avmm_gpio_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] ID_VALUE        = ID_VALUE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic [3:0]       avs_byteenable,
    output logic [31:0]      avs_readdata,
    output logic             avs_readdatavalid,
    output logic             avs_waitrequest,
    input  logic [KEY_W-1:0] key_n,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic             irq
);

    logic [IN_W-1:0]  deb_bits;
    gpio_in_t         deb_in;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] key_rise;
    logic [LED_W-1:0] led_out;
    logic [KEY_W-1:0] edge_flags;
    logic [KEY_W-1:0] irq_mask;
    logic [KEY_W-1:0] edge_clear;
    logic [31:0]      mode_rd;
    logic [31:0]      rd_mux;
    logic             wr_led;
    logic             wr_mode;
    logic             wr_edge;
    logic             wr_mask;
    logic             unused_bits;

    assign avs_waitrequest = 1'b0;

    gpio_debounce #(
        .WIDTH          (IN_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    ({sw, ~key_n}),
        .deb    (deb_bits)
    );

    assign deb_in   = gpio_in_t'(deb_bits);
    assign key_rise = deb_in.key & ~key_q;

    assign wr_led  = avs_write && (avs_address == ADDR_LED_OUT) && avs_byteenable[0];
    assign wr_mode = avs_write && (avs_address == ADDR_LED_MODE);
    assign wr_edge = avs_write && (avs_address == ADDR_EDGE);
    assign wr_mask = avs_write && (avs_address == ADDR_IRQ_MASK);

    assign edge_clear  = wr_edge ? avs_writedata[KEY_W-1:0] : '0;
    assign unused_bits = ^{avs_writedata[31:LED_W], avs_byteenable[3:1], wr_mode};

`ifdef AVMM_GPIO_HEARTBEAT_EN
    logic        led_mode;
    logic [27:0] hb_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_mode <= 1'b0;
            hb_count <= '0;
        end else begin
            hb_count <= hb_count + 28'd1;
            if (wr_mode) begin
                led_mode <= avs_writedata[0];
            end
        end
    end

    assign led     = led_mode ? hb_count[27:20] : led_out;
    assign mode_rd = {31'b0, led_mode};
`else
    assign led     = led_out;
    assign mode_rd = '0;
`endif

    // Mux reads current register state, so a same-cycle write is seen by the next read only.
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_LED_OUT:  rd_mux = {{(32-LED_W){1'b0}}, led_out};
            ADDR_LED_MODE: rd_mux = mode_rd;
            ADDR_INPUTS:   rd_mux = {24'b0, deb_in.sw, 2'b00, deb_in.key};
            ADDR_EDGE:     rd_mux = {{(32-KEY_W){1'b0}}, edge_flags};
            ADDR_IRQ_MASK: rd_mux = {{(32-KEY_W){1'b0}}, irq_mask};
            ADDR_ID:       rd_mux = ID_VALUE;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            led_out           <= '0;
            edge_flags        <= '0;
            irq_mask          <= '0;
            key_q             <= '0;
            irq               <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
            if (wr_led) begin
                led_out <= avs_writedata[LED_W-1:0];
            end
            if (wr_mask) begin
                irq_mask <= avs_writedata[KEY_W-1:0];
            end
            key_q      <= deb_in.key;
            // New press edges win over a simultaneous write-one-to-clear.
            edge_flags <= (edge_flags & ~edge_clear) | key_rise;
            irq        <= |(edge_flags & irq_mask);
        end
    end

endmodule

// File: tb/tb_avmm_gpio_agent.sv
// Bench for avmm_gpio_agent: random bus traffic and pin activity against a cycle reference model.
// Build with AVMM_GPIO_HEARTBEAT_EN defined to exercise the heartbeat LED mode.
module tb_avmm_gpio_agent;
    import avmm_gpio_pkg::*;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  avs_byteenable = '0;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_waitrequest;
    logic [1:0]  key_n = 2'b11;
    logic [3:0]  sw = '0;
    logic [7:0]  led;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic mon_en = 1'b0;
    logic [31:0] exp_q[$];

    // Reference model state (values after the most recent clock edge).
    logic [7:0]  m_led_out;
    logic        m_mode;
    logic [1:0]  m_edge;
    logic [1:0]  m_mask;
    logic        m_irq;
    logic [5:0]  m_deb;
    logic [5:0]  m_old;
    logic [5:0]  m_s;
    logic [1:0]  m_pending;
    logic        m_irq_n;
    logic [27:0] m_hb;
    int          m_run[6];
    logic [5:0]  m_pipe[$];

    always #10 clk = ~clk;

    avmm_gpio_agent #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .avs_address      (avs_address),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_byteenable   (avs_byteenable),
        .avs_readdata     (avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .avs_waitrequest  (avs_waitrequest),
        .key_n            (key_n),
        .sw               (sw),
        .led              (led),
        .irq              (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'b0, m_led_out};
`ifdef AVMM_GPIO_HEARTBEAT_EN
            3'd1:    return {31'b0, m_mode};
`endif
            3'd2:    return {24'b0, m_deb[5:2], 2'b00, m_deb[1:0]};
            3'd3:    return {30'b0, m_edge};
            3'd4:    return {30'b0, m_mask};
            3'd5:    return 32'h4445_3130;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [7:0] m_led();
`ifdef AVMM_GPIO_HEARTBEAT_EN
        return m_mode ? m_hb[27:20] : m_led_out;
`else
        return m_led_out;
`endif
    endfunction

    // Reference model: register file, pin history and debounce rule evaluated per clock.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_led_out = '0; m_mode = 1'b0; m_edge = '0; m_mask = '0; m_irq = 1'b0;
            m_deb = '0; m_pending = '0; m_hb = '0;
            for (int i = 0; i < 6; i++) m_run[i] = 0;
            m_pipe.delete();
            m_pipe.push_back(6'd0);
            m_pipe.push_back(6'd0);
            exp_q.delete();
        end else begin
            if (avs_read) exp_q.push_back(m_read(avs_address));
            m_irq_n = |(m_edge & m_mask);
            m_edge = (m_edge & ~((avs_write && avs_address == 3'd3) ? avs_writedata[1:0] : 2'b00))
                     | m_pending;
            if (avs_write && avs_address == 3'd0 && avs_byteenable[0]) m_led_out = avs_writedata[7:0];
            if (avs_write && avs_address == 3'd1) m_mode = avs_writedata[0];
            if (avs_write && avs_address == 3'd4) m_mask = avs_writedata[1:0];
            m_hb = m_hb + 28'd1;
            // Pins seen two edges ago; a bit flips after DB consecutive disagreeing edges.
            m_pipe.push_back({sw, ~key_n});
            m_s = m_pipe.pop_front();
            m_old = m_deb;
            for (int i = 0; i < 6; i++) begin
                if (m_s[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_deb[i] = m_s[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pending = m_deb[1:0] & ~m_old[1:0];
            m_irq = m_irq_n;
        end
    end

    // Monitor: compares read responses against the expected queue and outputs against the model.
    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            if (avs_readdatavalid) begin
                if (exp_q.size() == 0) check("rdv_unexpected", {31'b0, avs_readdatavalid}, 32'd0);
                else check("readdata", avs_readdata, exp_q.pop_front());
            end else if (exp_q.size() != 0) begin
                check("rdv_missing", {31'b0, avs_readdatavalid}, 32'd1);
                void'(exp_q.pop_front());
            end
            check("led", {24'b0, led}, {24'b0, m_led()});
            check("irq", {31'b0, irq}, {31'b0, m_irq});
            check("waitrequest", {31'b0, avs_waitrequest}, 32'd0);
        end
    end

    task automatic bus(input logic rd, input logic wr, input logic [2:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d; avs_byteenable = be;
        @(negedge clk);
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        bus(1'b0, 1'b1, a, d, be);
        idle();
    endtask

    task automatic rd(input logic [2:0] a);
        bus(1'b1, 1'b0, a, 32'd0, 4'd0);
        idle();
    endtask

    initial begin
        int budget;
        repeat (3) @(negedge clk);
        check("reset_readdata", avs_readdata, 32'd0);
        check("reset_rdv", {31'b0, avs_readdatavalid}, 32'd0);
        check("reset_led", {24'b0, led}, 32'd0);
        check("reset_irq", {31'b0, irq}, 32'd0);
        reset_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        wr(3'd0, 32'h0000_00A5, 4'hF);
        check("led_write", {24'b0, led}, 32'hA5);
        wr(3'd0, 32'h0000_003C, 4'h0);
        check("led_be0", {24'b0, led}, 32'hA5);

        bus(1'b1, 1'b0, 3'd5, 32'd0, 4'd0);
        check("rdv_latency", {31'b0, avs_readdatavalid}, 32'd1);
        check("id_value", avs_readdata, 32'h4445_3130);
        bus(1'b1, 1'b0, 3'd6, 32'd0, 4'd0);
        bus(1'b1, 1'b0, 3'd7, 32'd0, 4'd0);
        check("addr7_zero", avs_readdata, 32'd0);
        idle();
        check("rdv_drop", {31'b0, avs_readdatavalid}, 32'd0);

        wr(3'd1, 32'd1, 4'hF);
        rd(3'd1);
`ifndef AVMM_GPIO_HEARTBEAT_EN
        check("mode_ignored_led", {24'b0, led}, 32'hA5);
`endif
        wr(3'd1, 32'd0, 4'hF);

        wr(3'd4, 32'd1, 4'hF);
        key_n = 2'b10;
        repeat (9) @(negedge clk);
        check("irq_press", {31'b0, irq}, 32'd1);
        rd(3'd2);
        rd(3'd3);
        key_n = 2'b11;
        repeat (2) @(negedge clk);
        key_n = 2'b10;
        repeat (10) @(negedge clk);
        rd(3'd2);
        rd(3'd3);

        key_n = 2'b11;
        repeat (10) @(negedge clk);
        key_n = 2'b10;
        budget = 20;
        while (m_pending == 2'b00 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("press_edge_seen", {31'b0, m_pending[0]}, 32'd1);
        wr(3'd3, 32'd1, 4'hF);
        check("collision_irq", {31'b0, irq}, 32'd1);
        rd(3'd3);
        wr(3'd3, 32'd1, 4'hF);
        @(negedge clk);
        check("w1c_irq", {31'b0, irq}, 32'd0);
        rd(3'd3);

`ifdef AVMM_GPIO_HEARTBEAT_EN
        wr(3'd1, 32'd1, 4'hF);
        rd(3'd1);
        force dut.hb_count = 28'h0FFF_FFFF;
        m_hb = 28'h0FFF_FFFF;
        #1;
        check("hb_ff", {24'b0, led}, 32'hFF);
        release dut.hb_count;
        @(negedge clk);
        check("hb_wrap", {24'b0, led}, 32'h00);
        wr(3'd1, 32'd0, 4'hF);
`endif

        for (int n = 0; n < 400; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 11) == 0) begin
                key_n = 2'($urandom_range(0, 3));
                sw = 4'($urandom_range(0, 15));
            end
            case (op)
                0, 1, 2, 3: bus(1'b1, 1'b0, 3'($urandom_range(0, 7)), 32'd0, 4'd0);
                4, 5:       bus(1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
                6:          bus(1'b0, 1'b1, 3'($urandom_range(3, 4)), 32'($urandom_range(0, 3)), 4'hF);
                7:          bus(1'b1, 1'b1, 3'($urandom_range(0, 4)), $urandom, 4'hF);
                default:    idle();
            endcase
        end
        idle();

        key_n = 2'b11;
        wr(3'd0, 32'h5A, 4'h1);
        avs_read = 1'b1; avs_address = 3'd5;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_rdv", {31'b0, avs_readdatavalid}, 32'd0);
        check("rst_led", {24'b0, led}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        avs_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(3'd3);
        rd(3'd0);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
